// File: rtl/sar_scan_sched.sv
// sar_scan_sched: walks an enabled-channel mask, running one SAR conversion per
// channel, and hands each settled code out on a valid/ready port tagged with the
// channel it came from.
module sar_scan_sched #(
    parameter int N        = 8,
    parameter int NCH      = 4,
    parameter int CW       = 2,
    parameter int T_SAMPLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           cont,
    input  logic [NCH-1:0] ch_en,
    output logic           sar_rst_n,
    output logic           sample,
    output logic [CW-1:0]  ch_sel,
    input  logic           sar_last_cycle,
    input  logic [N-1:0]   sar_dq,
    output logic [N-1:0]   res_data,
    output logic [CW-1:0]  res_ch,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           busy,
    output logic           err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_CONV,
        S_RES1,
        S_RES2,
        S_HOLD
    } state_t;

    // One counter serves both the sample phase (counting down) and the CONV watchdog (counting up).
    localparam int CNT_MAX = ((T_SAMPLE + 1) > (N + 2)) ? (T_SAMPLE + 1) : (N + 2);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_SAMPLE_FIRST = CNT_W'(T_SAMPLE);
    localparam logic [CNT_W-1:0] C_SAMPLE_NEXT  = CNT_W'(T_SAMPLE + 1);
    localparam logic [CNT_W-1:0] C_WD_LAST      = CNT_W'(N + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NCH-1:0]   r_en;
    logic [CW-1:0]    r_ch;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_data;
    logic [CW-1:0]    r_res_ch;
    logic             r_valid;
    logic             r_err;

    logic [NCH-1:0]   w_above;
    logic             w_has_next;
    logic [CW-1:0]    w_next_ch;
    logic [CW-1:0]    w_wrap_ch;
    logic [CW-1:0]    w_ch_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cap;
    logic             w_start_ok;
    logic             w_wd_trip;

    // Index of the lowest set bit of a mask (0 when the mask is empty).
    function automatic logic [CW-1:0] f_lowest(input logic [NCH-1:0] m);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) idx = CW'(i);
        end
        return idx;
    endfunction

    // Enabled channels strictly above the one currently selected.
    always_comb begin
        w_above = '0;
        for (int i = 0; i < NCH; i++) begin
            w_above[i] = r_en[i] && (i > int'(r_ch));
        end
    end

    assign w_has_next = |w_above;
    assign w_next_ch  = f_lowest(w_above);
    assign w_wrap_ch  = f_lowest(r_en);

    // Next-state, counter and SAR/mux control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch;
        w_cap       = 1'b0;
        w_start_ok  = 1'b0;
        w_wd_trip   = 1'b0;
        sar_rst_n   = 1'b0;
        sample      = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && (|ch_en)) begin
                    w_start_ok  = 1'b1;
                    w_ch_nxt    = f_lowest(ch_en);
                    w_cnt_nxt   = C_SAMPLE_FIRST;
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // Entered from a finished conversion, the first cycle keeps the
                // switch open while the mux moves to the new channel.
                sample    = (r_cnt <= C_SAMPLE_FIRST);
                w_cnt_nxt = r_cnt - C_ONE;
                if (r_cnt == C_ONE) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                sar_rst_n = 1'b1;
                w_cnt_nxt = r_cnt + C_ONE;
                if (sar_last_cycle) begin
                    w_state_nxt = S_RES1;
                end else if (r_cnt == C_WD_LAST) begin
                    w_wd_trip   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RES1: begin
                sar_rst_n   = 1'b1;
                w_state_nxt = S_RES2;
            end
            S_RES2, S_HOLD: begin
                // The SAR stays out of reset so dq holds while the port is stalled.
                sar_rst_n = 1'b1;
                if (!r_valid || res_ready) begin
                    w_cap = 1'b1;
                    if (w_has_next) begin
                        w_ch_nxt    = w_next_ch;
                        w_cnt_nxt   = C_SAMPLE_NEXT;
                        w_state_nxt = S_SAMPLE;
                    end else if (cont) begin
                        w_ch_nxt    = w_wrap_ch;
                        w_cnt_nxt   = C_SAMPLE_NEXT;
                        w_state_nxt = S_SAMPLE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus scan mask, result port and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_en     <= '0;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_res_ch <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_start_ok) begin
                r_en <= ch_en;
            end
            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_wd_trip) begin
                r_err <= 1'b1;
            end
            if (w_cap) begin
                r_data   <= sar_dq;
                r_res_ch <= r_ch;
                r_valid  <= 1'b1;
            end else if (res_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ch_sel    = r_ch;
    assign res_data  = r_data;
    assign res_ch    = r_res_ch;
    assign res_valid = r_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_sar_scan_sched.sv
// Testbench for sar_scan_sched: behavioural SAR controller model, directed scans,
// and a scoreboard queue checked by an independent result monitor.
module tb_sar_scan_sched;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cont;
    logic [3:0] ch_en;
    logic       sar_rst_n;
    logic       sample;
    logic [1:0] ch_sel;
    logic       sar_last_cycle;
    logic [7:0] sar_dq;
    logic [7:0] res_data;
    logic [1:0] res_ch;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic       err;

    sar_scan_sched dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .ch_en(ch_en),
        .sar_rst_n(sar_rst_n), .sample(sample), .ch_sel(ch_sel),
        .sar_last_cycle(sar_last_cycle), .sar_dq(sar_dq),
        .res_data(res_data), .res_ch(res_ch), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SAR controller model: counts cycles out of reset, raises last_cycle on the
    // N-th, and shows the final code from two cycles later (LSB wrong one cycle before).
    logic [7:0] code_q[$];
    logic [7:0] cur_code = 8'h00;
    int         rcnt = 0;
    bit         lc_en = 1'b1;

    always @(posedge clk) begin
        if (!sar_rst_n) begin
            rcnt <= 0;
        end else begin
            if (rcnt == 0) begin
                if (code_q.size() != 0) cur_code <= code_q.pop_front();
                else cur_code <= 8'hEE;
            end
            if (rcnt < 31) rcnt <= rcnt + 1;
        end
    end

    assign sar_last_cycle = lc_en && sar_rst_n && (rcnt == N - 1);

    always_comb begin
        sar_dq = 8'h00;
        if (rcnt >= N + 1) sar_dq = cur_code;
        else if (rcnt == N) sar_dq = cur_code ^ 8'h01;
    end

    // Scoreboard: expected channel, code and presentation cycle of each result.
    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
        int         at;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_mon;

    task automatic expect_res(input logic [1:0] ch, input logic [7:0] data, input int at);
        exp_t e;
        e.ch = ch;
        e.data = data;
        e.at = at;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: got ch %0d data %02h at cycle %0d, expected no result",
                         res_ch, res_data, cyc);
            end else begin
                e_mon = exp_q.pop_front();
                chk("sb_data", 32'(res_data), 32'(e_mon.data));
                chk("sb_ch", 32'(res_ch), 32'(e_mon.ch));
                chk("sb_cycle", cyc, e_mon.at);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    int t0;
    int t1;

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; ch_en = 4'b0000; res_ready = 1'b1;
        repeat (3) tick();
        chk("rst_sar_rst_n", 32'(sar_rst_n), 0);
        chk("rst_sample", 32'(sample), 0);
        chk("rst_ch_sel", 32'(ch_sel), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_ch", 32'(res_ch), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Single scan over channels 0 and 2.
        code_q.delete();
        code_q.push_back(8'hA5); code_q.push_back(8'h3C);
        t0 = cyc;
        expect_res(2'd0, 8'hA5, t0 + 13);
        expect_res(2'd2, 8'h3C, t0 + 26);
        ch_en = 4'b0101; cont = 1'b0; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            chk("t1_sample", 32'(sample), 32'(k == 1 || k == 2 || k == 14 || k == 15));
            if (k == 1)  chk("t1_ch_sel_first", 32'(ch_sel), 0);
            if (k == 2)  chk("t1_sar_rst_n_sample", 32'(sar_rst_n), 0);
            if (k == 3)  chk("t1_sar_rst_n_conv", 32'(sar_rst_n), 1);
            if (k == 14) chk("t1_ch_sel_second", 32'(ch_sel), 2);
            if (k == 14) chk("t1_valid_one_cycle_a", 32'(res_valid), 0);
            if (k == 25) chk("t1_busy_before", 32'(busy), 1);
            if (k == 26) chk("t1_busy_after", 32'(busy), 0);
            if (k == 27) chk("t1_valid_one_cycle_b", 32'(res_valid), 0);
        end
        chk("t1_sb_drain", exp_q.size(), 0);

        // Continuous mode on channel 3; the mask change mid-scan must not matter.
        code_q.delete();
        code_q.push_back(8'h11); code_q.push_back(8'h22); code_q.push_back(8'h33);
        t0 = cyc;
        expect_res(2'd3, 8'h11, t0 + 13);
        expect_res(2'd3, 8'h22, t0 + 26);
        expect_res(2'd3, 8'h33, t0 + 39);
        ch_en = 4'b1000; cont = 1'b1; start = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 1)  start = 1'b0;
            if (k == 3)  ch_en = 4'b0001;
            if (k == 30) cont = 1'b0;
            if (k == 14) chk("t2_ch_sel_wrap1", 32'(ch_sel), 3);
            if (k == 27) chk("t2_ch_sel_wrap2", 32'(ch_sel), 3);
            if (k == 38) chk("t2_busy_last_conv", 32'(busy), 1);
            if (k == 39) chk("t2_busy_idle", 32'(busy), 0);
            if (k == 42) chk("t2_sample_idle", 32'(sample), 0);
        end
        chk("t2_sb_drain", exp_q.size(), 0);

        // Backpressure: first result parks on the port, second in HOLD.
        code_q.delete();
        code_q.push_back(8'h5A); code_q.push_back(8'hC3);
        t0 = cyc;
        expect_res(2'd0, 8'h5A, t0 + 33);
        expect_res(2'd1, 8'hC3, t0 + 34);
        ch_en = 4'b0011; cont = 1'b0; res_ready = 1'b0; start = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            tick();
            if (k == 1)  start = 1'b0;
            if (k == 33) res_ready = 1'b1;
            if (k == 20 || k == 32) begin
                chk("t3_hold_data", 32'(res_data), 32'h5A);
                chk("t3_hold_ch", 32'(res_ch), 0);
                chk("t3_hold_valid", 32'(res_valid), 1);
            end
            if (k == 30) begin
                chk("t3_hold_sar_rst_n", 32'(sar_rst_n), 1);
                chk("t3_hold_sample", 32'(sample), 0);
                chk("t3_hold_busy", 32'(busy), 1);
            end
            if (k == 35) chk("t3_valid_drop", 32'(res_valid), 0);
        end
        chk("t3_sb_drain", exp_q.size(), 0);

        // Watchdog: last_cycle never comes; the following start clears err.
        code_q.delete();
        lc_en = 1'b0;
        t0 = cyc;
        ch_en = 4'b0001; cont = 1'b0; start = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 1)  start = 1'b0;
            if (k == 12) begin
                chk("t4_err_before", 32'(err), 0);
                chk("t4_sar_rst_n_before", 32'(sar_rst_n), 1);
            end
            if (k == 13) begin
                chk("t4_err_set", 32'(err), 1);
                chk("t4_sar_rst_n_trip", 32'(sar_rst_n), 0);
                chk("t4_busy_trip", 32'(busy), 0);
            end
            if (k == 20) begin
                chk("t4_err_sticky", 32'(err), 1);
                lc_en = 1'b1;
                code_q.push_back(8'h77);
                t1 = cyc;
                expect_res(2'd0, 8'h77, t1 + 13);
                start = 1'b1;
            end
            if (k == 21) begin
                start = 1'b0;
                chk("t4_err_cleared", 32'(err), 0);
            end
        end
        chk("t4_sb_drain", exp_q.size(), 0);

        // Ignored requests: empty mask in IDLE, and a start during CONV.
        code_q.delete();
        ch_en = 4'b0000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_empty_busy", 32'(busy), 0);
        chk("t5_empty_sample", 32'(sample), 0);
        code_q.push_back(8'h9B);
        t0 = cyc;
        expect_res(2'd1, 8'h9B, t0 + 13);
        ch_en = 4'b0010; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (k == 5) begin
                ch_en = 4'b1111;
                start = 1'b1;
            end
            if (k == 6) begin
                start = 1'b0;
                chk("t5_conv_ch_sel", 32'(ch_sel), 1);
                chk("t5_conv_sar_rst_n", 32'(sar_rst_n), 1);
            end
            if (k == 12) chk("t5_busy_res2", 32'(busy), 1);
            if (k == 13) chk("t5_busy_done", 32'(busy), 0);
        end
        chk("t5_sb_drain", exp_q.size(), 0);

        // Reset in the middle of the second conversion, result still pending.
        code_q.delete();
        code_q.push_back(8'h61); code_q.push_back(8'h62);
        ch_en = 4'b0011; cont = 1'b0; res_ready = 1'b0; start = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (k == 17) begin
                chk("t6_pending_valid", 32'(res_valid), 1);
                chk("t6_pending_data", 32'(res_data), 32'h61);
                rst = 1'b1;
            end
            if (k == 18) begin
                rst = 1'b0;
                chk("t6_rst_sar_rst_n", 32'(sar_rst_n), 0);
                chk("t6_rst_valid", 32'(res_valid), 0);
                chk("t6_rst_busy", 32'(busy), 0);
                chk("t6_rst_data", 32'(res_data), 0);
                chk("t6_rst_ch_sel", 32'(ch_sel), 0);
            end
            if (k == 20) begin
                code_q.delete();
                code_q.push_back(8'h4D);
                res_ready = 1'b1;
                t1 = cyc;
                expect_res(2'd2, 8'h4D, t1 + 13);
                ch_en = 4'b0100;
                start = 1'b1;
            end
            if (k == 21) start = 1'b0;
        end
        chk("t6_sb_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
